// File: rtl/des_seq_pkg.sv
// Shared types and constants for the DES block sequencer.
package des_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        ROUND,
        WR0,
        WR1,
        DONE
    } seq_state_e;

    localparam logic [3:0] ROUND_LAST    = 4'd15;
    localparam int         BLOCK_LATENCY = 21;

endpackage

// File: rtl/des_block_sequencer_if.sv
// Control, RAM and DES-core signals of the block sequencer, bundled for port use.
interface des_block_sequencer_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              abort;
    logic              decrypt;
    logic              cbc_en;
    logic [63:0]       iv;
    logic [ADDR_W-2:0] num_blocks;

    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_en;

    logic [63:0]       des_in;
    logic [3:0]        des_round;
    logic              des_decrypt;
    logic [63:0]       des_out;

    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] blocks_done;

    // The sequencer side.
    modport slave (
        input  start, abort, decrypt, cbc_en, iv, num_blocks, rd_data, des_out,
        output rd_addr, wr_addr, wr_data, wr_en, des_in, des_round, des_decrypt,
               busy, done, blocks_done
    );

    // The host / RAM / core side.
    modport master (
        output start, abort, decrypt, cbc_en, iv, num_blocks, rd_data, des_out,
        input  rd_addr, wr_addr, wr_data, wr_en, des_in, des_round, des_decrypt,
               busy, done, blocks_done
    );

endinterface

// File: rtl/des_chain_unit.sv
// CBC chaining: pre-whitening on encrypt, post-whitening on decrypt, next chain value.
module des_chain_unit (
    input  logic        cbc_en,
    input  logic        decrypt,
    input  logic [63:0] blk_in,
    input  logic [63:0] chain,
    input  logic [63:0] des_in_cur,
    input  logic [63:0] des_out,
    output logic [63:0] des_in_next,
    output logic [63:0] result,
    output logic [63:0] chain_next
);

    // NOTE: every output gets a default first so no path through the
    // branches can leave one unassigned and infer a latch.
    always_comb begin
        des_in_next = blk_in;
        result      = des_out;
        chain_next  = chain;
        if (cbc_en) begin
            if (decrypt) begin
                // The block being decrypted is still held as the core input.
                result     = des_out ^ chain;
                chain_next = des_in_cur;
            end else begin
                des_in_next = blk_in ^ chain;
                chain_next  = des_out;
            end
        end
    end

endmodule

// File: rtl/des_block_sequencer.sv
// Streams 64-bit blocks from an input RAM through an external DES core into an
// output RAM, 21 cycles per block, in ECB or CBC mode.
module des_block_sequencer #(
    parameter int ADDR_W = 9
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    des_block_sequencer_if.slave bus
);
    import des_seq_pkg::*;

    localparam logic [ADDR_W-1:0] FULL_DEPTH = {1'b1, {(ADDR_W-1){1'b0}}};

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [63:0]       des_in_q, des_in_d;
    logic [3:0]        des_round_q, des_round_d;
    logic              decrypt_q, decrypt_d;
    logic              cbc_en_q, cbc_en_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [63:0]       chain_q, chain_d;
    logic [31:0]       lo_q, lo_d;
    logic [63:0]       res_q, res_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] blocks_done_q, blocks_done_d;

    logic [63:0]       cu_des_in, cu_result, cu_chain;
    logic [ADDR_W-1:0] nxt_blk;
    logic [ADDR_W-1:0] blk_addr;

    des_chain_unit u_chain (
        .cbc_en      (cbc_en_q),
        .decrypt     (decrypt_q),
        .blk_in      ({bus.rd_data, lo_q}),
        .chain       (chain_q),
        .des_in_cur  (des_in_q),
        .des_out     (bus.des_out),
        .des_in_next (cu_des_in),
        .result      (cu_result),
        .chain_next  (cu_chain)
    );

    // blocks_done doubles as the index of the block in flight.
    assign nxt_blk  = blocks_done_q + ADDR_W'(1);
    assign blk_addr = {blocks_done_q[ADDR_W-2:0], 1'b0};

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_en_d       = 1'b0;
        des_in_d      = des_in_q;
        des_round_d   = des_round_q;
        decrypt_d     = decrypt_q;
        cbc_en_d      = cbc_en_q;
        count_d       = count_q;
        chain_d       = chain_q;
        lo_d          = lo_q;
        res_d         = res_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        blocks_done_d = blocks_done_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    decrypt_d     = bus.decrypt;
                    cbc_en_d      = bus.cbc_en;
                    count_d       = (bus.num_blocks == '0) ? FULL_DEPTH : {1'b0, bus.num_blocks};
                    chain_d       = bus.iv;
                    rd_addr_d     = '0;
                    wr_addr_d     = '0;
                    blocks_done_d = '0;
                    busy_d        = 1'b1;
                    state_d       = RD0;
                end
            end
            RD0: begin
                rd_addr_d = {rd_addr_q[ADDR_W-1:1], 1'b1};
                state_d   = RD1;
            end
            RD1: begin
                lo_d    = bus.rd_data;
                state_d = RD2;
            end
            RD2: begin
                des_in_d    = cu_des_in;
                des_round_d = '0;
                state_d     = ROUND;
            end
            ROUND: begin
                if (des_round_q == ROUND_LAST) begin
                    res_d     = cu_result;
                    chain_d   = cu_chain;
                    wr_addr_d = blk_addr;
                    wr_data_d = cu_result[31:0];
                    wr_en_d   = 1'b1;
                    state_d   = WR0;
                end else begin
                    des_round_d = des_round_q + 4'd1;
                end
            end
            WR0: begin
                wr_addr_d = {wr_addr_q[ADDR_W-1:1], 1'b1};
                wr_data_d = res_q[63:32];
                wr_en_d   = 1'b1;
                state_d   = WR1;
            end
            WR1: begin
                blocks_done_d = nxt_blk;
                if (nxt_blk == count_q) begin
                    state_d = DONE;
                end else begin
                    rd_addr_d = {nxt_blk[ADDR_W-2:0], 1'b0};
                    state_d   = RD0;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the state decided, including a pending done.
        if (bus.abort) begin
            state_d       = IDLE;
            wr_en_d       = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            blocks_done_d = blocks_done_q;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            des_in_q      <= '0;
            des_round_q   <= '0;
            decrypt_q     <= 1'b0;
            cbc_en_q      <= 1'b0;
            count_q       <= '0;
            chain_q       <= '0;
            lo_q          <= '0;
            res_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            blocks_done_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            des_in_q      <= des_in_d;
            des_round_q   <= des_round_d;
            decrypt_q     <= decrypt_d;
            cbc_en_q      <= cbc_en_d;
            count_q       <= count_d;
            chain_q       <= chain_d;
            lo_q          <= lo_d;
            res_q         <= res_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    assign bus.rd_addr     = rd_addr_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.des_in      = des_in_q;
    assign bus.des_round   = des_round_q;
    assign bus.des_decrypt = decrypt_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.blocks_done = blocks_done_q;

endmodule

// File: doc/des_block_sequencer.md
DES_BLOCK_SEQUENCER -- requirements
Module: des_block_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the 32-bit word address width of both RAM ports.
REQ-002 SHALL have port sys_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to process a buffer.
REQ-005 SHALL have port abort, input, 1, a one-cycle request to terminate the current run.
REQ-006 SHALL have port decrypt, input, 1, 0 = encrypt and 1 = decrypt; latched at start.
REQ-007 SHALL have port cbc_en, input, 1, 0 = ECB and 1 = CBC; latched at start.
REQ-008 SHALL have port iv, input, 64, the CBC initial vector; latched at start.
REQ-009 SHALL have port num_blocks, input, ADDR_W-1, the 64-bit block count; 0 means 2^(ADDR_W-1); latched at start.
REQ-010 SHALL have port rd_addr, output, ADDR_W, the input RAM word address.
REQ-011 SHALL have port rd_data, input, 32, the input RAM data, valid 1 cycle after rd_addr.
REQ-012 SHALL have port wr_addr, output, ADDR_W, the output RAM word address.
REQ-013 SHALL have port wr_data, output, 32, the output RAM write data.
REQ-014 SHALL have port wr_en, output, 1, the output RAM write strobe.
REQ-015 SHALL have port des_in, output, 64, the DES core input block.
REQ-016 SHALL have port des_round, output, 4, the DES core roundSel.
REQ-017 SHALL have port des_decrypt, output, 1, the DES core direction (latched decrypt).
REQ-018 SHALL have port des_out, input, 64, the DES core result, valid on the edge where des_round==15.
REQ-019 SHALL have port busy, output, 1, high from start acceptance until done or abort.
REQ-020 SHALL have port done, output, 1, a one-cycle pulse at normal completion.
REQ-021 SHALL have port blocks_done, output, ADDR_W, the count of blocks written in the current or last run.

Function
REQ-022 SHALL implement states IDLE, RD0, RD1, RD2, ROUND, WR0, WR1 and DONE.
REQ-023 IDLE SHALL behave as follows: when start=1, latch the configuration, clear the addresses and blocks_done, load chain from iv, and go to RD0; start SHALL be ignored in every other state.
REQ-024 RD0 SHALL present rd_addr=2k for block k; RD1 SHALL capture the low word and present 2k+1; RD2 SHALL capture the high word, form des_in, set des_round=0, and go to ROUND.
REQ-025 Word order SHALL be low 32 bits at the even address and high 32 bits at the odd address, for both RAMs.
REQ-026 ROUND SHALL increment des_round each cycle; on des_round==15 it SHALL capture the result and go to WR0 (16 cycles).
REQ-027 ECB SHALL use des_in = P and result = des_out.
REQ-028 CBC encrypt SHALL use des_in = P XOR chain, result = des_out, chain <= result.
REQ-029 CBC decrypt SHALL use des_in = C, result = des_out XOR chain, chain <= C.
REQ-030 WR0 SHALL write the result low word to wr_addr=2k; WR1 SHALL write the high word to 2k+1 and increment blocks_done.
REQ-031 After WR1, the block SHALL go to DONE if blocks_done equals the latched count (0 is treated as full depth, with address wrap to 0 not reached); otherwise it SHALL go to RD0.
REQ-032 DONE SHALL pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-033 Latency SHALL be 21 cycles per block; done SHALL rise exactly 21*N+1 cycles after the start edge.
REQ-034 abort SHALL take priority over every transition: the block SHALL return to IDLE next cycle, wr_en=0, busy=0, no done pulse, and blocks_done holds its value.
REQ-035 start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-036 wr_en SHALL be high only in WR0 and WR1.

Reset
REQ-037 On reset, the block SHALL enter IDLE; wr_en, done and busy SHALL be 0; rd_addr, wr_addr, des_round, blocks_done, des_in and chain SHALL be 0.
REQ-038 Reset mid-run SHALL discard the operation with no further writes.

Structure
REQ-039 Package des_seq_pkg SHALL hold the state enumeration, the ROUND_LAST=15 constant and the per-block latency constant 21.
REQ-040 The CBC XOR/chain update SHALL be a sub-module des_chain_unit.
REQ-041 The DES core and the RAMs SHALL remain external.

Verification
REQ-042 ECB encrypt with N=1, P=0123456789ABCDEF and key 133457799BBCDFF1 SHALL write 85E813540F0AB405 as wr 0=0F0AB405 and wr 1=85E81354; done SHALL pulse 22 cycles after start.
REQ-043 CBC encrypt then CBC decrypt with N=4 and IV=0 SHALL reproduce the 4 plaintext blocks, and block 1 ciphertext SHALL match a reference model.
REQ-044 num_blocks=0 SHALL give 256 blocks (ADDR_W=9), 512 writes, blocks_done=256 (wraps to 0 in 9 bits? use 9-bit = 256), done at 5377 cycles.
REQ-045 start pulsed during block 2 ROUND SHALL be ignored, and the run SHALL complete unchanged.
REQ-046 abort in WR0 of block 3 SHALL leave blocks_done=2, busy=0 next cycle, no WR1 write and no done pulse.
REQ-047 reset asserted in ROUND SHALL produce all outputs 0 next cycle, and a following start SHALL run normally.
